asrm_ram_subword_responder: RTL and testbench
=============================================

ASRM_RAM_SUBWORD_RESPONDER -- requirements
Module: asrm_ram_subword_responder

Interface
REQ-001 SHALL have parameter wordsize, default 16, RAM word width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter addr_width, default 16, width of the CPU byte address.
REQ-003 clk  input  1  clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  1  CPU access request; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; captured with req.
REQ-007 size  input  2  00 full word, 01 32-bit, 10 16-bit, 11 8-bit (same encoding as status register bits [2:1]); captured with req.
REQ-008 addr  input  addr_width  byte address; captured with req.
REQ-009 wdata  input  wordsize  write data, right-aligned; captured with req.
REQ-010 rdata  output  wordsize  read data, right-aligned and zero-extended; registered.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high from the cycle after acceptance through the ack cycle.
REQ-013 ram_addr  output  addr_width  RAM word index.
REQ-014 ram_we  output  1  RAM write strobe.
REQ-015 ram_din  output  wordsize  RAM write data.
REQ-016 ram_dout  input  wordsize  RAM read data, valid one cycle after ram_addr is presented.

Function
REQ-017 Effective width SHALL be the size width when that width is strictly less than wordsize; otherwise the access SHALL be full-word.
REQ-018 ram_addr SHALL be addr shifted right by log2(wordsize/8); lane byte offset SHALL be the low address bits rounded down to the effective-width alignment.
REQ-019 Lanes SHALL be little-endian: offset 0 maps to bits [7:0].
REQ-020 FSM states SHALL be IDLE, ISSUE, CAPTURE, DONE.
REQ-021 In IDLE, req=1 at edge N SHALL latch we/size/addr/wdata and enter ISSUE for cycle N+1.
REQ-022 In ISSUE, ram_addr SHALL be driven; full-word write SHALL assert ram_we with ram_din=wdata and go to DONE; all other accesses SHALL go to CAPTURE.
REQ-023 In CAPTURE, a read SHALL register rdata = selected lane of ram_dout, zero-extended; a narrow write SHALL assert ram_we with ram_din = ram_dout with the selected lane replaced by the low bits of wdata; then go to DONE.
REQ-024 In DONE, ack SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-025 Latency: full-word write ack in cycle N+2; reads and narrow writes ack in cycle N+3.
REQ-026 req SHALL be ignored outside IDLE, including the DONE cycle; there is no queueing.
REQ-027 ram_we SHALL be high only in ISSUE (full write) or CAPTURE (narrow write); ram_addr SHALL hold the latched index from ISSUE through DONE.
REQ-028 rdata SHALL hold its last value until the next read completes; writes SHALL NOT alter rdata.
REQ-029 Bytes outside the selected lane SHALL never change on a narrow write.

Reset
REQ-030 On reset=0 at an edge: state IDLE; rdata 0; ack 0; busy 0; ram_we 0; ram_addr 0; ram_din 0.
REQ-031 Reset mid-operation SHALL abort with no ack, and ram_we SHALL be 0 from the next cycle.

Structure
REQ-032 Size encodings and FSM state encodings SHALL live in the shared define header used by the asrm blocks.
REQ-033 Lane extract and merge logic SHALL be one combinational sub-module, asrm_lane_merge.

Verification (wordsize=32, RAM word 0 = 0x11223344)
REQ-034 Read, size 11, addr 1 -> ack at N+3, rdata 0x00000033.
REQ-035 Write, size 11, addr 2, wdata 0xFFFFFFAB -> single ram_we in CAPTURE, word 0 becomes 0x11AB3344, ack at N+3.
REQ-036 Read, size 10, addr 3 -> aligned to offset 2, rdata 0x00001122.
REQ-037 Write, size 01, addr 0, wdata 0xCAFEBABE -> treated as full word, ram_we in ISSUE, ack at N+2, word 0 = 0xCAFEBABE.
REQ-038 req held high for 10 cycles -> one access per IDLE visit, at most one ack per operation, no ack without a prior acceptance.
REQ-039 reset=0 during CAPTURE of a narrow write -> no ack, ram_we 0 from the next cycle, word 0 unchanged.

Source files
------------

// File: rtl/asrm_ram_subword_responder_pkg.sv
// Shared encodings for the asrm blocks: access size codes, responder FSM states,
// and the effective-lane-width helper.
package asrm_ram_subword_responder_pkg;

   localparam logic [1:0] SIZE_FULL = 2'b00;
   localparam logic [1:0] SIZE_32   = 2'b01;
   localparam logic [1:0] SIZE_16   = 2'b10;
   localparam logic [1:0] SIZE_8    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } asrm_state_t;

   // A requested width that is not narrower than the RAM word degrades to a full-word access.
   function automatic logic [3:0] eff_bytes(input logic [1:0] size, input int word_bytes);
      int nb;
      case (size)
         SIZE_32: nb = 4;
         SIZE_16: nb = 2;
         SIZE_8:  nb = 1;
         default: nb = word_bytes;
      endcase
      if (nb >= word_bytes) nb = word_bytes;
      return 4'(nb);
   endfunction

endpackage

// File: rtl/asrm_ram_subword_responder_lane_merge.sv
// asrm_lane_merge: combinational little-endian lane extract (zero-extended)
// and read-modify-write merge of a sub-word lane into a RAM word.
module asrm_lane_merge
   import asrm_ram_subword_responder_pkg::*;
#(
   parameter int wordsize = 16
) (
   input  logic [wordsize-1:0] i_word,
   input  logic [wordsize-1:0] i_wdata,
   input  logic [3:0]          i_off,
   input  logic [3:0]          i_nbytes,
   output logic [wordsize-1:0] o_extract,
   output logic [wordsize-1:0] o_merged
);

   localparam int NB = wordsize / 8;

   int w_off;
   int w_nb;

   assign w_off = int'(i_off);
   assign w_nb  = int'(i_nbytes);

   // b walks output bytes, s walks source bytes; only the lane pairs ever match.
   always_comb begin
      o_extract = '0;
      o_merged  = i_word;
      for (int b = 0; b < NB; b++) begin
         for (int s = 0; s < NB; s++) begin
            if (b < w_nb && s == w_off + b)
               o_extract[b*8 +: 8] = i_word[s*8 +: 8];
            if (b >= w_off && b < w_off + w_nb && s == b - w_off)
               o_merged[b*8 +: 8] = i_wdata[s*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/asrm_ram_subword_responder.sv
// CPU-to-RAM responder handling full-word and sub-word reads/writes on a
// one-cycle-latency RAM, using read-modify-write for narrow stores.
//
// state      | meaning
// IDLE       | waiting for req; latches the access when req is high
// ISSUE      | ram_addr presented; full-word write commits here
// CAPTURE    | ram_dout valid; read lane registered or narrow write merged
// DONE       | ack pulse, then back to IDLE
module asrm_ram_subword_responder
   import asrm_ram_subword_responder_pkg::*;
#(
   parameter int wordsize   = 16,
   parameter int addr_width = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic [addr_width-1:0] addr,
   input  logic [wordsize-1:0]   wdata,
   output logic [wordsize-1:0]   rdata,
   output logic                  ack,
   output logic                  busy,
   output logic [addr_width-1:0] ram_addr,
   output logic                  ram_we,
   output logic [wordsize-1:0]   ram_din,
   input  logic [wordsize-1:0]   ram_dout
);

   localparam int NBYTES = wordsize / 8;
   localparam int OFFW   = $clog2(NBYTES);

   asrm_state_t           r_state;
   asrm_state_t           w_next;
   logic                  r_we;
   logic                  r_full;
   logic [3:0]            r_nb;
   logic [3:0]            r_off;
   logic [wordsize-1:0]   r_wdata;
   logic [addr_width-1:0] r_ram_addr;
   logic [wordsize-1:0]   r_rdata;

   logic [3:0]            w_nb;
   logic [3:0]            w_low;
   logic [3:0]            w_off;
   logic                  w_ram_we;
   logic [wordsize-1:0]   w_ram_din;
   logic [wordsize-1:0]   w_extract;
   logic [wordsize-1:0]   w_merged;

   assign w_nb  = eff_bytes(size, NBYTES);
   assign w_low = 4'(addr & addr_width'(NBYTES - 1));
   assign w_off = w_low & ~(w_nb - 4'd1);

   asrm_lane_merge #(.wordsize(wordsize)) u_lane (
      .i_word    (ram_dout),
      .i_wdata   (r_wdata),
      .i_off     (r_off),
      .i_nbytes  (r_nb),
      .o_extract (w_extract),
      .o_merged  (w_merged)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_we       <= 1'b0;
         r_full     <= 1'b0;
         r_nb       <= '0;
         r_off      <= '0;
         r_wdata    <= '0;
         r_ram_addr <= '0;
         r_rdata    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && req) begin
            r_we       <= we;
            r_full     <= (w_nb == 4'(NBYTES));
            r_nb       <= w_nb;
            r_off      <= w_off;
            r_wdata    <= wdata;
            r_ram_addr <= addr >> OFFW;
         end
         if (r_state == ST_CAPTURE && !r_we)
            r_rdata <= w_extract;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ram_we  = 1'b0;
      w_ram_din = '0;
      case (r_state)
         ST_IDLE: begin
            if (req) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (r_we && r_full) begin
               w_ram_we  = 1'b1;
               w_ram_din = r_wdata;
               w_next    = ST_DONE;
            end else begin
               w_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (r_we) begin
               w_ram_we  = 1'b1;
               w_ram_din = w_merged;
            end
            w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Gating with reset keeps an aborted write from landing on the abort edge.
   assign ram_we   = w_ram_we & reset;
   assign ram_din  = reset ? w_ram_din : '0;
   assign ram_addr = r_ram_addr;
   assign rdata    = r_rdata;
   assign ack      = (r_state == ST_DONE);
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_asrm_ram_subword_responder.sv
// Self-checking bench: directed literal cases plus randomized traffic, compared
// every cycle against a transaction-level model with a shadow memory.
module tb_asrm_ram_subword_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        busy;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   asrm_ram_subword_responder #(.wordsize(32), .addr_width(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .size     (size),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ack      (ack),
      .busy     (busy),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h11223344;
      return (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
   endfunction

   // Environment RAM: registered read, one-cycle latency.
   logic        ram_init;
   logic [31:0] mem [16];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else if (ram_we) begin
         mem[ram_addr[3:0]] <= ram_din;
      end
      ram_dout <= mem[ram_addr[3:0]];
   end

   // Reference model helpers: plain byte arithmetic on a 4-byte word.
   function automatic int width_bytes(input logic [1:0] sz);
      int nb;
      case (sz)
         2'b01:   nb = 4;
         2'b10:   nb = 2;
         2'b11:   nb = 1;
         default: nb = 4;
      endcase
      return (nb < 4) ? nb : 4;
   endfunction

   function automatic logic [31:0] lane_mask(input int nb);
      if (nb >= 4) return 32'hFFFFFFFF;
      return (32'h1 << (8 * nb)) - 32'h1;
   endfunction

   function automatic logic [31:0] ref_extract(input logic [31:0] w, input int off, input int nb);
      return (w >> (8 * off)) & lane_mask(nb);
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] d,
                                             input int off, input int nb);
      return (w & ~(lane_mask(nb) << (8 * off))) | ((d & lane_mask(nb)) << (8 * off));
   endfunction

   // Transaction model: m_phase counts cycles since acceptance, ack when it reaches m_lat.
   logic [31:0] ref_mem [16];
   int          m_phase = 0;
   int          m_lat   = 3;
   logic        m_we    = 1'b0;
   logic        m_full  = 1'b0;
   int          m_nb    = 4;
   int          m_off   = 0;
   int          m_word  = 0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdata = '0;
   int          m_acks  = 0;

   always @(posedge clk) begin
      if (ram_init)
         for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      if (!reset) begin
         m_phase = 0;
         m_rdata = '0;
      end else if (m_phase == 0) begin
         if (req) begin
            m_we    = we;
            m_nb    = width_bytes(size);
            m_off   = ((int'(addr) % 4) / m_nb) * m_nb;
            m_word  = int'(addr) / 4;
            m_wdata = wdata;
            m_full  = (m_nb == 4);
            m_lat   = (we && m_full) ? 2 : 3;
            m_phase = 1;
         end
      end else if (m_phase == m_lat) begin
         m_phase = 0;
      end else begin
         m_phase = m_phase + 1;
         if (m_phase == m_lat) begin
            m_acks = m_acks + 1;
            if (m_we) ref_mem[m_word] = ref_merge(ref_mem[m_word], m_wdata, m_off, m_nb);
            else      m_rdata = ref_extract(ref_mem[m_word], m_off, m_nb);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   logic chk_en = 1'b0;
   logic exp_we;
   always @(negedge clk) begin
      if (chk_en) begin
         exp_we = reset && m_phase != 0 && m_we &&
                  (m_full ? (m_phase == 1) : (m_phase == 2));
         chk("busy", 64'(busy), 64'(m_phase != 0));
         chk("ack", 64'(ack), 64'(m_phase != 0 && m_phase == m_lat));
         chk("ram_we", 64'(ram_we), 64'(exp_we));
         chk("rdata", 64'(rdata), 64'(m_rdata));
         if (m_phase != 0) chk("ram_addr", 64'(ram_addr), 64'(m_word));
         if (exp_we)
            chk("ram_din", 64'(ram_din),
                64'(ref_merge(ref_mem[m_word], m_wdata, m_off, m_nb)));
         if (m_phase != 0 && m_phase == m_lat)
            chk("mem_word", 64'(mem[m_word]), 64'(ref_mem[m_word]));
      end
   end

   // Called just after a posedge; returns aligned just after the edge ending the ack cycle.
   task automatic do_op(input logic w, input logic [1:0] sz, input logic [15:0] a,
                        input logic [31:0] d, output int lat);
      req = 1'b1; we = w; size = sz; addr = a; wdata = d;
      @(posedge clk); #1;
      req = 1'b0;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (ack) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
      if (lat < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL ack_timeout: no ack within 8 cycles");
      end else begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int lat;
      int acks;
      reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
      ram_init = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_rdata", 64'(rdata), 64'h0);
      chk("rst_ack", 64'(ack), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_ram_we", 64'(ram_we), 64'h0);
      chk("rst_ram_addr", 64'(ram_addr), 64'h0);
      chk("rst_ram_din", 64'(ram_din), 64'h0);
      @(posedge clk); #1;
      reset = 1'b1; ram_init = 1'b0; chk_en = 1'b1;
      @(posedge clk); #1;

      do_op(1'b0, 2'b11, 16'd1, 32'h0, lat);
      chk("lat_rd8", 64'(lat), 64'd3);
      chk("rdata_rd8", 64'(rdata), 64'h00000033);

      do_op(1'b0, 2'b10, 16'd3, 32'h0, lat);
      chk("lat_rd16", 64'(lat), 64'd3);
      chk("rdata_rd16", 64'(rdata), 64'h00001122);

      do_op(1'b1, 2'b11, 16'd2, 32'hFFFFFFAB, lat);
      chk("lat_wr8", 64'(lat), 64'd3);
      chk("mem_wr8", 64'(mem[0]), 64'h11AB3344);

      do_op(1'b1, 2'b01, 16'd0, 32'hCAFEBABE, lat);
      chk("lat_wr32", 64'(lat), 64'd2);
      chk("mem_wr32", 64'(mem[0]), 64'hCAFEBABE);
      chk("rdata_kept", 64'(rdata), 64'h00001122);

      // req held for 10 edges: accepts on edges 1, 5, 9 only
      acks = 0;
      req = 1'b1; we = 1'b0; size = 2'b11; addr = 16'd5; wdata = '0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #1;
         if (i >= 10) req = 1'b0;
         @(negedge clk);
         if (ack) acks++;
      end
      @(posedge clk); #1;
      chk("held_req_acks", 64'(acks), 64'd3);

      // abort a narrow write in CAPTURE
      req = 1'b1; we = 1'b1; size = 2'b11; addr = 16'd0; wdata = 32'h00000055;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ram_we", 64'(ram_we), 64'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ack) acks++;
         chk("abort_ram_we_after", 64'(ram_we), 64'h0);
         @(posedge clk); #1;
      end
      chk("abort_no_ack", 64'(acks), 64'd0);
      chk("abort_mem", 64'(mem[0]), 64'hCAFEBABE);

      for (int c = 0; c < 2500; c++) begin
         req   = ($urandom_range(0, 2) != 0);
         we    = 1'($urandom);
         size  = 2'($urandom);
         addr  = 16'($urandom_range(0, 63));
         wdata = $urandom;
         reset = ($urandom_range(0, 59) != 0);
         @(posedge clk); #1;
      end
      reset = 1'b1; req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("model_acks_seen", 64'(m_acks > 100), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
